load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Memory-access stage directly downstream of the ALU in the RV32I core. Consumes the ALU result as the effective address and rs2 as store data. Runs a req/gnt/rvalid transaction on the data-memory bus, with byte-lane alignment of store data and sign/zero extension of load data. Stalls the core until the access completes and flags misaligned, illegal and timed-out accesses.

Parameters:
TIMEOUT, 255, max cycles waiting for mem_rvalid_i in RESP before bus error (1..65535)

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
load_i  input  1  current instruction is a load
store_i  input  1  current instruction is a store
funct3_i  input  3  RV32I funct3 of the load/store
addr_i  input  32  effective address (ALU result)
wdata_i  input  32  store data (rs2)
stall_o  output  1  hold PC/pipeline this cycle
rdata_o  output  32  extended load result, valid when done_o
done_o  output  1  one-cycle pulse: access finished
misalign_o  output  1  with done_o: misaligned address
illegal_o  output  1  with done_o: bad funct3 or load_i&store_i
bus_err_o  output  1  with done_o: mem_err_i or timeout
mem_req_o  output  1  bus request
mem_we_o  output  1  1 = write
mem_addr_o  output  32  word-aligned address ({addr[31:2],2'b00})
mem_wstrb_o  output  4  byte strobes (0 for loads)
mem_wdata_o  output  32  lane-aligned store data
mem_gnt_i  input  1  request accepted this cycle
mem_rvalid_i  input  1  response valid (loads and stores)
mem_rdata_i  input  32  read word
mem_err_i  input  1  response error, qualified by mem_rvalid_i

Behaviour:
- Reset (async, immediate): state IDLE. All outputs 0, including stall_o and mem_req_o. Timeout counter 0. Capture registers 0.
- stall_o = (load_i|store_i) & ~done_o. Combinational. The core advances only in the done cycle.
- States: IDLE, REQ, RESP, DONE.
- IDLE: if load_i|store_i, capture funct3, addr, wdata and direction.
  - Error path: illegal (load funct3 in {011,110,111}; store funct3 > 010; load_i&store_i) or misaligned (H with addr[0]=1; W with addr[1:0]≠0). Go to DONE with the matching flag set and no bus activity. Illegal takes priority over misalign.
  - Otherwise go to REQ.
- REQ: mem_req_o=1 with mem_addr/we/wstrb/wdata held stable from the capture registers. On mem_gnt_i go to RESP and clear the counter. The request drops the cycle after grant.
- RESP: counter increments each cycle.
  - On mem_rvalid_i go to DONE; latch extended read data (loads) and bus_err = mem_err_i.
  - If counter reaches TIMEOUT-1 with no rvalid, go to DONE with bus_err_o=1.
  - mem_rvalid_i is ignored in every state other than RESP.
- DONE: done_o=1 for exactly one cycle; flags valid that cycle. Next state is IDLE. A new request is sampled only in IDLE, so back-to-back accesses have at least one idle cycle between them.
- Minimum latency for a legal access with gnt on the first REQ cycle and rvalid on the first RESP cycle: done_o asserts 3 cycles after the request is first seen (IDLE→REQ→RESP→DONE).
- Store strobes, off = addr[1:0]:
  - SB: 4'b0001<<off, wdata = {4{wdata[7:0]}}
  - SH: 4'b0011<<off, wdata = {2{wdata[15:0]}}
  - SW: 4'b1111, wdata = full word
- Load extract: shifted = mem_rdata_i >> (8*off). LB sign-extends [7:0], LH sign-extends [15:0], LW passes through, LBU/LHU zero-extend.
- rdata_o is 0 for stores and for any errored access. It holds its value only during done_o; otherwise it is 0.
- Inputs changing mid-transaction have no effect, because captured values are used.
- Reset mid-transaction: abort immediately. No done_o is produced, and the bus sees the request withdrawn.

Test Plan:
- LW addr=0x100, gnt cycle 1, rvalid cycle 2 with rdata=0xDEADBEEF -> mem_addr_o=0x100, wstrb=0; done_o on cycle 3, rdata_o=0xDEADBEEF; stall_o high cycles 0-2, low in cycle 3.
- LB/LBU addr=0x103, rdata=0x80FF_0000 -> LB gives 0xFFFFFF80; LBU gives 0x00000080.
- SH addr=0x206, wdata=0x1234ABCD -> mem_addr_o=0x204, wstrb=4'b1100, mem_wdata_o=0xABCDABCD, mem_we_o=1; done_o after rvalid with no error flags.
- LW addr=0x102 -> no mem_req_o ever; done_o and misalign_o high on cycle 1. funct3=011 load -> illegal_o=1 with misalign_o=0.
- gnt held low 5 cycles, then gnt -> mem_req_o stays high with stable address until gnt. TIMEOUT=4 and no rvalid -> done_o with bus_err_o=1 exactly 4 cycles after entering RESP.
- rst_n low while in RESP -> stall_o and mem_req_o go to 0 without waiting for a clock edge. After release, a new LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: captures an ALU-computed access, runs one req/gnt/rvalid bus
// transaction, lane-aligns store data and extends load data, stalling the core until done.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        misalign_o,
  output logic        illegal_o,
  output logic        bus_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i
);

  typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        we_q, we_d;
  logic        mis_q, mis_d;
  logic        ill_q, ill_d;
  logic        berr_q, berr_d;

  logic        req_in, is_ill, is_mis;
  logic [1:0]  off;
  logic [3:0]  strb_new;
  logic [31:0] wdata_new, shifted, load_ext;

  assign req_in = load_i | store_i;
  assign off    = addr_i[1:0];

  // Decode of the incoming request, used only in the capture cycle.
  always_comb begin
    is_ill = (load_i & store_i)
           | (load_i & ((funct3_i == 3'b011) | (funct3_i == 3'b110) | (funct3_i == 3'b111)))
           | (store_i & (funct3_i > 3'b010));
    is_mis = ((funct3_i[1:0] == 2'b01) & addr_i[0])
           | ((funct3_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00));
    strb_new  = 4'b1111;
    wdata_new = wdata_i;
    unique case (funct3_i[1:0])
      2'b00: begin
        strb_new  = 4'b0001 << off;
        wdata_new = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        strb_new  = 4'b0011 << off;
        wdata_new = {2{wdata_i[15:0]}};
      end
      default: begin
        strb_new  = 4'b1111;
        wdata_new = wdata_i;
      end
    endcase
  end

  always_comb begin
    shifted  = mem_rdata_i >> {addr_q[1:0], 3'b000};
    load_ext = '0;
    case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_ext = shifted;
      3'b100:  load_ext = {24'd0, shifted[7:0]};
      3'b101:  load_ext = {16'd0, shifted[15:0]};
      default: load_ext = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    wstrb_d  = wstrb_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    mis_d    = mis_q;
    ill_d    = ill_q;
    berr_d   = berr_q;
    unique case (state_q)
      StIdle: begin
        if (req_in) begin
          addr_d   = addr_i;
          funct3_d = funct3_i;
          we_d     = store_i & ~load_i;
          wstrb_d  = (store_i & ~load_i) ? strb_new : 4'b0000;
          wdata_d  = wdata_new;
          rdata_d  = '0;
          berr_d   = 1'b0;
          ill_d    = is_ill;
          mis_d    = ~is_ill & is_mis;
          state_d  = (is_ill | is_mis) ? StDone : StReq;
        end
      end
      StReq: begin
        if (mem_gnt_i) begin
          state_d = StResp;
          cnt_d   = '0;
        end
      end
      StResp: begin
        cnt_d = cnt_q + 16'd1;
        if (mem_rvalid_i) begin
          state_d = StDone;
          berr_d  = mem_err_i;
          rdata_d = (we_q | mem_err_i) ? 32'd0 : load_ext;
        end else if (cnt_q == TimeoutLast) begin
          state_d = StDone;
          berr_d  = 1'b1;
          rdata_d = '0;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wstrb_q  <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      mis_q    <= 1'b0;
      ill_q    <= 1'b0;
      berr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      wstrb_q  <= wstrb_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      mis_q    <= mis_d;
      ill_q    <= ill_d;
      berr_q   <= berr_d;
    end
  end

  assign done_o      = (state_q == StDone);
  // rst_n gates stall so the core is released the instant reset asserts.
  assign stall_o     = rst_n & req_in & ~done_o;
  assign rdata_o     = done_o ? rdata_q : 32'd0;
  assign misalign_o  = done_o & mis_q;
  assign illegal_o   = done_o & ill_q;
  assign bus_err_o   = done_o & berr_q;
  assign mem_req_o   = (state_q == StReq);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = {addr_q[31:2], 2'b00};
  assign mem_wstrb_o = wstrb_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: bench-driven bus responder, scoreboard of expected
// completions, and immediate-assertion checks at each comparison point.
module tb_load_store_unit;

  localparam int unsigned Timeout = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_i, store_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, done_o, misalign_o, illegal_o, bus_err_o;
  logic [31:0] rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [31:0] mem_rdata_i;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(Timeout)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (load_i),
    .store_i      (store_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .stall_o      (stall_o),
    .rdata_o      (rdata_o),
    .done_o       (done_o),
    .misalign_o   (misalign_o),
    .illegal_o    (illegal_o),
    .bus_err_o    (bus_err_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wstrb_o  (mem_wstrb_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_err_i    (mem_err_i)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        mis;
    logic        ill;
    logic        berr;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   gc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_err_i    = 1'b0;
    mem_rdata_i  = '0;
  endtask

  // One access; c counts cycles from the one in which the request is first presented.
  task automatic access(input string name, input logic ld, input logic st,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input int gnt_wait, input int rv_wait, input logic [31:0] rd,
                        input logic err, input exp_t e, input logic [3:0] e_strb,
                        input logic [31:0] e_wdata, input int e_done, output int gnt_cyc);
    int   req_n, resp_n;
    bit   granted, seen;
    exp_t want;
    @(posedge clk); #1;
    load_i = ld; store_i = st; funct3_i = f3; addr_i = a; wdata_i = wd;
    sb_q.push_back(e);
    req_n = 0; resp_n = 0; granted = 0; seen = 0; gnt_cyc = -1;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      idle_bus();
      // Spurious response while idle must be ignored.
      if (c == 0) begin
        mem_rvalid_i = 1'b1; mem_err_i = 1'b1; mem_rdata_i = 32'hA5A5_5A5A;
      end
      if (done_o) begin
        seen = 1;
        check({name, " done_cycle"}, c, e_done);
        check({name, " stall_in_done"}, stall_o, 0);
        want = sb_q.pop_front();
        check({name, " rdata"}, rdata_o, want.rdata);
        check({name, " misalign"}, misalign_o, want.mis);
        check({name, " illegal"}, illegal_o, want.ill);
        check({name, " bus_err"}, bus_err_o, want.berr);
      end else begin
        check({name, " stall"}, stall_o, 1);
        if (mem_req_o) begin
          check({name, " addr"}, mem_addr_o, a & 32'hFFFF_FFFC);
          check({name, " we"}, mem_we_o, st);
          check({name, " wstrb"}, mem_wstrb_o, e_strb);
          if (st) check({name, " wdata"}, mem_wdata_o, e_wdata);
          if (req_n == gnt_wait) begin
            mem_gnt_i = 1'b1; gnt_cyc = c; granted = 1;
          end
          req_n++;
        end else if (granted) begin
          if (resp_n == rv_wait) begin
            mem_rvalid_i = 1'b1; mem_rdata_i = rd; mem_err_i = err;
          end
          resp_n++;
        end
      end
      // Captured values must be used from here on.
      if (c == 1) begin
        addr_i = ~a; wdata_i = ~wd; funct3_i = f3 ^ 3'b001;
      end
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $error("FAIL %s no_done: observed none expected done_o within 40 cycles", name);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end
    check({name, " bus_used"}, req_n > 0, e_done != 1);
    @(posedge clk); #1;
    load_i = 0; store_i = 0; idle_bus();
  endtask

  initial begin
    rst_n = 1'b0; load_i = 1'b1; store_i = 1'b0; funct3_i = 3'b010;
    addr_i = 32'h100; wdata_i = '0;
    idle_bus();
    #12;
    check("reset stall", stall_o, 0);
    check("reset done", done_o, 0);
    check("reset req", mem_req_o, 0);
    check("reset rdata", rdata_o, 0);
    check("reset addr", mem_addr_o, 0);
    check("reset wstrb", mem_wstrb_o, 0);
    check("reset flags", {misalign_o, illegal_o, bus_err_o, mem_we_o}, 0);
    load_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    access("LW", 1, 0, 3'b010, 32'h100, 0, 0, 0, 32'hDEADBEEF, 0,
           '{32'hDEADBEEF, 0, 0, 0}, 4'b0000, 0, 3, gc);
    access("LB", 1, 0, 3'b000, 32'h103, 0, 0, 0, 32'h80FF_0000, 0,
           '{32'hFFFF_FF80, 0, 0, 0}, 4'b0000, 0, 3, gc);
    access("LBU", 1, 0, 3'b100, 32'h103, 0, 0, 0, 32'h80FF_0000, 0,
           '{32'h0000_0080, 0, 0, 0}, 4'b0000, 0, 3, gc);
    access("LH", 1, 0, 3'b001, 32'h102, 0, 0, 1, 32'h8001_1234, 0,
           '{32'hFFFF_8001, 0, 0, 0}, 4'b0000, 0, 4, gc);
    access("LHU", 1, 0, 3'b101, 32'h102, 0, 0, 0, 32'h8001_1234, 0,
           '{32'h0000_8001, 0, 0, 0}, 4'b0000, 0, 3, gc);
    access("SH", 0, 1, 3'b001, 32'h206, 32'h1234ABCD, 0, 0, 32'hFFFF_FFFF, 0,
           '{0, 0, 0, 0}, 4'b1100, 32'hABCD_ABCD, 3, gc);
    access("SB", 0, 1, 3'b000, 32'h101, 32'h0000_0055, 0, 0, 0, 0,
           '{0, 0, 0, 0}, 4'b0010, 32'h5555_5555, 3, gc);
    access("SW", 0, 1, 3'b010, 32'h300, 32'hCAFE_F00D, 0, 0, 0, 0,
           '{0, 0, 0, 0}, 4'b1111, 32'hCAFE_F00D, 3, gc);
    access("LW_mis", 1, 0, 3'b010, 32'h102, 0, 0, 0, 0, 0,
           '{0, 1, 0, 0}, 4'b0000, 0, 1, gc);
    access("SH_mis", 0, 1, 3'b001, 32'h201, 32'h1, 0, 0, 0, 0,
           '{0, 1, 0, 0}, 4'b0000, 0, 1, gc);
    access("L011_ill", 1, 0, 3'b011, 32'h100, 0, 0, 0, 0, 0,
           '{0, 0, 1, 0}, 4'b0000, 0, 1, gc);
    access("L110_ill_prio", 1, 0, 3'b110, 32'h003, 0, 0, 0, 0, 0,
           '{0, 0, 1, 0}, 4'b0000, 0, 1, gc);
    access("S011_ill", 0, 1, 3'b011, 32'h100, 0, 0, 0, 0, 0,
           '{0, 0, 1, 0}, 4'b0000, 0, 1, gc);
    access("LS_both_ill", 1, 1, 3'b010, 32'h100, 0, 0, 0, 0, 0,
           '{0, 0, 1, 0}, 4'b0000, 0, 1, gc);
    access("LW_gnt5", 1, 0, 3'b010, 32'h440, 0, 5, 0, 32'h0102_0304, 0,
           '{32'h0102_0304, 0, 0, 0}, 4'b0000, 0, 8, gc);
    check("LW_gnt5 gnt_cycle", gc, 6);
    access("LW_err", 1, 0, 3'b010, 32'h500, 0, 0, 0, 32'h1111_2222, 1,
           '{0, 0, 0, 1}, 4'b0000, 0, 3, gc);
    access("LW_timeout", 1, 0, 3'b010, 32'h600, 0, 0, -1, 0, 0,
           '{0, 0, 0, 1}, 4'b0000, 0, 6, gc);
    check("LW_timeout gnt_cycle", gc, 1);

    // Reset asserted mid-transaction: first in REQ, then in RESP.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      load_i = 1'b1; store_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h400;
      @(negedge clk);
      @(negedge clk);
      check("rst pre req", mem_req_o, 1);
      if (k == 1) begin
        mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        check("rst pre resp_stall", stall_o, 1);
      end
      #2 rst_n = 1'b0;
      #1;
      check("rst async stall", stall_o, 0);
      check("rst async req", mem_req_o, 0);
      check("rst async done", done_o, 0);
      @(posedge clk); #1;
      check("rst held done", done_o, 0);
      load_i = 1'b0;
      rst_n = 1'b1;
    end
    access("LW_after_rst", 1, 0, 3'b010, 32'h104, 0, 0, 0, 32'h7654_3210, 0,
           '{32'h7654_3210, 0, 0, 0}, 4'b0000, 0, 3, gc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
